// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-path FIFO controller:
// data/FIFO geometry defaults and the write/drain FSM state encodings.
package uart_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PUSH = 2'd1,
        W_HOLD = 2'd2
    } wr_state_e;

    typedef enum logic [2:0] {
        D_IDLE = 3'd0,
        D_POP  = 3'd1,
        D_LOAD = 3'd2,
        D_ACK  = 3'd3,
        D_DONE = 3'd4
    } drain_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous DATA_W x DEPTH register-array FIFO with registered read data.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrreq_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DATA_W-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W:0]   wr_cnt_q;
    logic [ADDR_W:0]   rd_cnt_q;
    logic [DATA_W-1:0] q_q;
    logic              push;
    logic              pop;

    // Counters carry one extra bit so a full FIFO is distinguishable from an empty one.
    assign count_o = wr_cnt_q - rd_cnt_q;
    assign full_o  = (count_o == FULL_CNT);
    assign empty_o = (count_o == '0);
    assign q_o     = q_q;

    assign push = wrreq_i && !full_o;
    assign pop  = rdreq_i && !empty_o;

    // NOTE: the storage array has no reset; only the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_cnt_q[ADDR_W-1:0]] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            q_q      <= '0;
        end else begin
            if (push) begin
                wr_cnt_q <= wr_cnt_q + CNT_ONE;
            end
            if (pop) begin
                rd_cnt_q <= rd_cnt_q + CNT_ONE;
                q_q      <= mem_q[rd_cnt_q[ADDR_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/tx_fifo_controller.sv
// UART transmit-side buffer: one FIFO push per rising edge of `write`, drained to the
// UART TX with a tx_start pulse and tx_busy handshake. Define TXF_OVERFLOW_EN for `overflow`.
module tx_fifo_controller
    import uart_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    input  logic              tx_busy,
    output logic              tx_start,
`ifdef TXF_OVERFLOW_EN
    output logic              overflow,
`endif
    output logic [DATA_W-1:0] tx_data
);

    wr_state_e         wr_state_q, wr_state_d;
    drain_state_e      dr_state_q, dr_state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              wrreq;
    logic              rdreq;
    logic              fifo_full;
    logic              fifo_empty;

    // ---------------- write FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            hold_q     <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        wr_state_d = wr_state_q;
        hold_d     = hold_q;
        case (wr_state_q)
            W_IDLE: begin
                if (write) begin
                    wr_state_d = W_PUSH;
                    hold_d     = data_in;
                end
            end
            W_PUSH:  wr_state_d = W_HOLD;
            W_HOLD: begin
                if (!write) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        wrreq = (wr_state_q == W_PUSH);
    end

    // ---------------- drain FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_state_q <= D_IDLE;
        end else begin
            dr_state_q <= dr_state_d;
        end
    end

    always_comb begin
        dr_state_d = dr_state_q;
        case (dr_state_q)
            D_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    dr_state_d = D_POP;
                end
            end
            D_POP:   dr_state_d = D_LOAD;
            D_LOAD:  dr_state_d = D_ACK;
            D_ACK: begin
                if (tx_busy) begin
                    dr_state_d = D_DONE;
                end
            end
            D_DONE: begin
                if (!tx_busy) begin
                    dr_state_d = D_IDLE;
                end
            end
            default: dr_state_d = D_IDLE;
        endcase
    end

    // tx_start is a pure state decode, so an asynchronous reset drops it immediately.
    always_comb begin
        rdreq    = (dr_state_q == D_POP);
        tx_start = (dr_state_q == D_LOAD);
    end

    // The FIFO read register is tx_data: it loads on the pop edge, so the byte is
    // already stable during the tx_start cycle and holds between frames.
    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wrreq_i (wrreq),
        .data_i  (hold_q),
        .rdreq_i (rdreq),
        .q_o     (tx_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (count)
    );

    assign full  = fifo_full;
    assign empty = fifo_empty;

`ifdef TXF_OVERFLOW_EN
    logic overflow_q;

    // Full is judged in the push cycle itself, even if a pop frees a slot at the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (wrreq && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_tx_fifo_controller.sv
// Self-checking bench for tx_fifo_controller: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed timing and data expectations.
module tb_tx_fifo_controller;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AW = 4;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          write      = 1'b0;
    logic [DW-1:0] data_in    = '0;
    logic          busy_force = 1'b0;
    logic          busy_auto  = 1'b0;
    logic          tx_busy;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          tx_start;
    logic [DW-1:0] tx_data;
`ifdef TXF_OVERFLOW_EN
    logic          overflow;
`endif

    assign tx_busy = busy_force | busy_auto;

    tx_fifo_controller #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .data_in  (data_in),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
`ifdef TXF_OVERFLOW_EN
        .overflow (overflow),
`endif
        .tx_data  (tx_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Bytes in the FIFO are a queue; a push lands the edge after the write rise is seen;
    // each frame goes: pop cycle, start cycle, wait for busy high, wait for busy low, ready.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_txdata    = '0;
    logic [DW-1:0] m_push_byte = '0;
    bit            m_push_now  = 1'b0;
    bit            m_pop_now   = 1'b0;
    bit            m_start_now = 1'b0;
    bit            m_prev_wr   = 1'b0;
    bit            m_ovf       = 1'b0;
    int            m_phase     = 0;

    always @(posedge clk or posedge rst) begin : model
        int sz;
        bit pop_next;
        if (rst) begin
            mq.delete();
            m_txdata    = '0;
            m_push_now  = 1'b0;
            m_pop_now   = 1'b0;
            m_start_now = 1'b0;
            m_prev_wr   = 1'b0;
            m_ovf       = 1'b0;
            m_phase     = 0;
        end else begin
            sz       = mq.size();
            pop_next = 1'b0;
            case (m_phase)
                0: if (sz > 0 && !tx_busy) begin pop_next = 1'b1; m_phase = 1; end
                1: if (m_start_now) m_phase = 2;
                2: if (tx_busy) m_phase = 3;
                default: if (!tx_busy) m_phase = 0;
            endcase
            if (m_pop_now) m_txdata = mq.pop_front();
            if (m_push_now) begin
                if (sz < DP) mq.push_back(m_push_byte);
                else m_ovf = 1'b1;
            end
            m_start_now = m_pop_now;
            m_pop_now   = pop_next;
            m_push_now  = write && !m_prev_wr;
            m_push_byte = data_in;
            m_prev_wr   = write;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("count", 32'(count), 32'(mq.size()));
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("full", 32'(full), 32'(mq.size() == DP));
            check("tx_start", 32'(tx_start), 32'(m_start_now));
            check("tx_data", 32'(tx_data), 32'(m_txdata));
`ifdef TXF_OVERFLOW_EN
            check("overflow", 32'(overflow), 32'(m_ovf));
`endif
        end
    end

    // ---------------- UART TX model and start recorder ----------------
    int            ucnt = 0;
    int            st_cyc[$];
    logic [DW-1:0] st_dat[$];

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            if (!rst) begin
                st_cyc.push_back(cyc);
                st_dat.push_back(tx_data);
            end
            ucnt = 11;
        end else if (ucnt > 0) begin
            busy_auto = (ucnt > 1);
            ucnt--;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_byte(input logic [DW-1:0] b);
        @(negedge clk);
        data_in = b;
        write   = 1'b1;
        repeat (2) @(negedge clk);
        write = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_quiet(input int budget, input string name);
        int n;
        n = 0;
        while (!(mq.size() == 0 && m_phase == 0 && !m_pop_now && !m_push_now &&
                 ucnt == 0 && !tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " settles"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_starts(input int num, input int budget, input string name);
        int n;
        n = 0;
        while (st_cyc.size() < num && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, " start count"}, 32'(st_cyc.size()), 32'(num));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin : stim
        int a;
        int s;

        // 1: reset state and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t1 tx_start", 32'(tx_start), 32'd0);
        check("t1 empty", 32'(empty), 32'd1);
        check("t1 count", 32'(count), 32'd0);
        check("t1 full", 32'(full), 32'd0);
        check("t1 tx_data", 32'(tx_data), 32'h00);
        repeat (20) @(negedge clk);
        check("t1 no start", 32'(st_cyc.size()), 32'd0);

        // 2: single byte, write held 5 cycles
        @(negedge clk);
        data_in = 8'hA5;
        write   = 1'b1;
        a       = cyc;
        repeat (5) @(negedge clk);
        write = 1'b0;
        repeat (25) @(negedge clk);
        check("t2 one start", 32'(st_cyc.size()), 32'd1);
        s = (st_cyc.size() > 0) ? st_cyc[0] : -1;
        check("t2 latency", 32'(s - a), 32'd4);
        check("t2 data", 32'((st_dat.size() > 0) ? st_dat[0] : 8'h00), 32'hA5);
        wait_quiet(100, "t2");

        // 3: three bytes back-to-back through the 10-cycle busy model
        st_cyc.delete();
        st_dat.delete();
        push_byte(8'h01);
        push_byte(8'h02);
        push_byte(8'h03);
        wait_starts(3, 200, "t3");
        for (int i = 0; i < 3; i++) begin
            check("t3 data", 32'((st_dat.size() > i) ? st_dat[i] : 8'h00), 32'(i + 1));
        end
        for (int i = 1; i < 3; i++) begin
            check("t3 gap", 32'((st_cyc.size() > i) ? st_cyc[i] - st_cyc[i-1] : 0), 32'd14);
        end
        wait_quiet(100, "t3");
`ifdef TXF_OVERFLOW_EN
        check("t3 overflow clear", 32'(overflow), 32'd0);
`endif

        // 4: fill while UART busy, 17th byte dropped, then drain in order
        st_cyc.delete();
        st_dat.delete();
        busy_force = 1'b1;
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        check("t4 count", 32'(count), 32'd16);
        check("t4 full", 32'(full), 32'd1);
`ifdef TXF_OVERFLOW_EN
        check("t4 overflow", 32'(overflow), 32'd1);
`endif
        @(negedge clk);
        busy_force = 1'b0;
        wait_starts(16, 600, "t4");
        for (int i = 0; i < 16; i++) begin
            check("t4 data", 32'((st_dat.size() > i) ? st_dat[i] : 8'hFF), 32'(i));
        end
        wait_quiet(100, "t4");
        check("t4 empty", 32'(empty), 32'd1);

        // 5: write rise lands on the same cycle as D_POP while full
        st_cyc.delete();
        st_dat.delete();
        busy_force = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h20 + i));
        check("t5 full", 32'(full), 32'd1);
        @(negedge clk);
        busy_force = 1'b0;
        data_in    = 8'hEE;
        write      = 1'b1;
        repeat (2) @(negedge clk);
        check("t5 count", 32'(count), 32'd15);
        check("t5 not full", 32'(full), 32'd0);
        write = 1'b0;
        wait_starts(15, 600, "t5");
        for (int i = 0; i < 15; i++) begin
            check("t5 data", 32'((st_dat.size() > i) ? st_dat[i] : 8'hFF), 32'(8'h20 + i));
        end
        wait_quiet(100, "t5");

        // 6: reset while waiting for the UART acknowledge with 4 bytes queued
        st_cyc.delete();
        st_dat.delete();
        busy_force = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h40 + i));
        @(negedge clk);
        busy_force = 1'b0;
        wait_starts(1, 20, "t6");
        @(posedge clk);
        #1;
        check("t6 queued", 32'(count), 32'd4);
        #1;
        rst = 1'b1;
        #1;
        check("t6 rst count", 32'(count), 32'd0);
        check("t6 rst empty", 32'(empty), 32'd1);
        check("t6 rst tx_start", 32'(tx_start), 32'd0);
        check("t6 rst full", 32'(full), 32'd0);
        check("t6 rst tx_data", 32'(tx_data), 32'h00);
`ifdef TXF_OVERFLOW_EN
        check("t6 rst overflow", 32'(overflow), 32'd0);
`endif
        st_cyc.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("t6 no start", 32'(st_cyc.size()), 32'd0);
        check("t6 empty", 32'(empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
